// File: rtl/spi_pkg.sv
// Shared definitions for the mode-0 SPI master: state encoding, mode constants
// and a frame-length helper.
package spi_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_HIGH  = 3'd2;
  localparam logic [2:0] ST_LOW   = 3'd3;
  localparam logic [2:0] ST_HOLD  = 3'd4;
  localparam logic [2:0] ST_GAP   = 3'd5;

  localparam logic CPOL      = 1'b0;
  localparam logic CPHA      = 1'b0;
  localparam logic MSB_FIRST = 1'b1;

  // Handshake edge to the next possible accept, in clk cycles.
  function automatic int frame_len(input int w, input int d);
    return d * (2 + 2 * w);
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Phase divider: load restarts a DIV-cycle interval, tc marks its last cycle.
module spi_clk_div #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic tc
);
  localparam int CW = $clog2(DIV + 1);
  localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)               cnt <= '0;
    else if (load)         cnt <= RELOAD;
    else if (cnt != '0)    cnt <= cnt - 1'b1;
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/spi_master_xfer.sv
// Mode-0, MSB-first SPI master moving one full-duplex word per frame,
// with a guaranteed slave-select gap between frames.
module spi_master_xfer
  import spi_pkg::*;
#(
  parameter int P_DATA_TEMP_WIDTH = 8,
  parameter int P_CLK_DIV         = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         tx_valid,
  output logic                         tx_ready,
  input  logic [P_DATA_TEMP_WIDTH-1:0] tx_data,
  output logic                         rx_valid,
  output logic [P_DATA_TEMP_WIDTH-1:0] rx_data,
  output logic                         busy,
  output logic                         spi_sclk,
  output logic                         spi_mosi,
  output logic                         spi_ss,
  input  logic                         spi_miso
);
  localparam int W  = P_DATA_TEMP_WIDTH;
  localparam int BW = $clog2(W + 1);
  localparam logic [BW-1:0] BITS = BW'(W);

  logic [2:0]    state;
  logic [W-1:0]  shift;
  logic [W:0]    shift_ext;
  logic [BW-1:0] bit_cnt;
  logic          hs, tc, div_load;

  assign tx_ready  = (state == ST_IDLE) && !rst;
  assign busy      = (state != ST_IDLE) && !rst;
  assign hs        = tx_valid && tx_ready;
  // Every timed state restarts the divider on its last cycle; GAP hands back to IDLE.
  assign div_load  = hs || (tc && (state != ST_IDLE) && (state != ST_GAP));
  assign shift_ext = {shift, spi_miso};

  spi_clk_div #(.DIV(P_CLK_DIV)) u_div (
    .clk  (clk),
    .rst  (rst),
    .load (div_load),
    .tc   (tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      shift    <= '0;
      bit_cnt  <= '0;
      spi_sclk <= CPOL;
      spi_ss   <= 1'b1;
      spi_mosi <= 1'b0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        ST_IDLE: if (hs) begin
          shift    <= tx_data;
          spi_mosi <= tx_data[W-1];
          spi_ss   <= 1'b0;
          bit_cnt  <= '0;
          state    <= ST_SETUP;
        end
        ST_SETUP, ST_LOW: if (tc) begin
          // MISO is captured on the same edge that raises SCLK.
          spi_sclk <= 1'b1;
          shift    <= shift_ext[W-1:0];
          bit_cnt  <= bit_cnt + 1'b1;
          state    <= ST_HIGH;
        end
        ST_HIGH: if (tc) begin
          spi_sclk <= 1'b0;
          if (bit_cnt == BITS) begin
            state <= ST_HOLD;
          end else begin
            spi_mosi <= shift[W-1];
            state    <= ST_LOW;
          end
        end
        ST_HOLD: if (tc) begin
          spi_ss   <= 1'b1;
          spi_mosi <= 1'b0;
          rx_data  <= shift;
          rx_valid <= 1'b1;
          state    <= ST_GAP;
        end
        ST_GAP: if (tc) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_xfer.sv
// Bench for spi_master_xfer: W=8/D=2 and W=4/D=1 instances checked cycle by
// cycle against timing and data derived from the frame rules.
module tb_spi_master_xfer;
  logic       clk = 1'b0;
  logic       rst, tx_valid, miso_drv, loop_mode, sel;
  logic [7:0] tx_data;
  int         tests = 0, fails = 0;
  bit         held = 1'b0;

  always #5 clk = ~clk;

  logic       ready8, rxv8, busy8, sclk8, mosi8, ss8, miso8;
  logic [7:0] rxd8;
  logic       ready4, rxv4, busy4, sclk4, mosi4, ss4, miso4;
  logic [3:0] rxd4;
  logic       tv8, tv4;

  assign tv8   = tx_valid & ~sel;
  assign tv4   = tx_valid & sel;
  assign miso8 = loop_mode ? mosi8 : miso_drv;
  assign miso4 = loop_mode ? mosi4 : miso_drv;

  spi_master_xfer #(.P_DATA_TEMP_WIDTH(8), .P_CLK_DIV(2)) dut (
    .clk(clk), .rst(rst), .tx_valid(tv8), .tx_ready(ready8), .tx_data(tx_data),
    .rx_valid(rxv8), .rx_data(rxd8), .busy(busy8), .spi_sclk(sclk8),
    .spi_mosi(mosi8), .spi_ss(ss8), .spi_miso(miso8)
  );

  spi_master_xfer #(.P_DATA_TEMP_WIDTH(4), .P_CLK_DIV(1)) dut4 (
    .clk(clk), .rst(rst), .tx_valid(tv4), .tx_ready(ready4), .tx_data(tx_data[3:0]),
    .rx_valid(rxv4), .rx_data(rxd4), .busy(busy4), .spi_sclk(sclk4),
    .spi_mosi(mosi4), .spi_ss(ss4), .spi_miso(miso4)
  );

  logic       o_ready, o_rxv, o_busy, o_sclk, o_mosi, o_ss;
  logic [7:0] o_rxd;
  assign o_ready = sel ? ready4 : ready8;
  assign o_rxv   = sel ? rxv4   : rxv8;
  assign o_busy  = sel ? busy4  : busy8;
  assign o_sclk  = sel ? sclk4  : sclk8;
  assign o_mosi  = sel ? mosi4  : mosi8;
  assign o_ss    = sel ? ss4    : ss8;
  assign o_rxd   = sel ? {4'b0, rxd4} : rxd8;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One frame on the selected instance; entered and left on a falling edge.
  task automatic run_frame(input bit s, input logic [7:0] tx_in, input bit loop,
                           input logic [7:0] sw, input bit hold,
                           input logic [7:0] next_data, input int abort_at);
    int W, D, SSE, FL, n, nrise, q, b;
    logic [7:0] mask, tx, exp_rx, mosi_seq;
    logic prev_sclk, any_v, ss_drop;
    sel = s;
    W = s ? 4 : 8;
    D = s ? 1 : 2;
    SSE = D * (1 + 2 * W);
    FL = spi_pkg::frame_len(W, D);
    mask = s ? 8'h0F : 8'hFF;
    tx = tx_in & mask;
    exp_rx = loop ? tx : (sw & mask);
    loop_mode = loop;
    n = 0;
    while (o_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    chk("ready_wait", 32'(o_ready), 32'd1);
    if (held) chk("b2b_accept_delay", 32'(n), 32'd0);
    held = hold;
    tx_valid = 1'b1;
    tx_data = tx_in;
    nrise = 0;
    miso_drv = sw[W-1];
    prev_sclk = 1'b0;
    mosi_seq = '0;
    @(posedge clk);
    for (int c = 1; c <= FL + 1; c++) begin
      @(negedge clk);
      if (c == 1) begin
        if (hold) tx_data = next_data;
        else begin tx_valid = 1'b0; tx_data = 8'($urandom); end
      end
      q = (c - 1) / D;
      b = (c - 1) / (2 * D);
      if (b > W - 1) b = W - 1;
      chk("ss", 32'(o_ss), 32'(c > SSE));
      chk("tx_ready", 32'(o_ready), 32'(c == FL + 1));
      chk("busy", 32'(o_busy), 32'(c != FL + 1));
      chk("rx_valid", 32'(o_rxv), 32'(c == SSE + 1));
      chk("sclk", 32'(o_sclk), 32'(c >= D + 1 && c <= 2 * W * D && (q % 2) == 1));
      chk("mosi", 32'(o_mosi), (c <= SSE) ? 32'(tx[W-1-b]) : 32'd0);
      if (c == SSE + 1) chk("rx_data", 32'(o_rxd), 32'(exp_rx));
      if (o_sclk && !prev_sclk) begin
        mosi_seq = {mosi_seq[6:0], o_mosi};
        nrise++;
      end
      prev_sclk = o_sclk;
      if (!o_sclk && nrise < W) miso_drv = sw[W-1-nrise];
      if (c == abort_at) begin
        rst = 1'b1;
        tx_valid = 1'b1;
        #1 chk("rst_tx_ready", 32'(o_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tx_valid = 1'b0;
        held = 1'b0;
        #1;
        chk("abort_ss", 32'(o_ss), 32'd1);
        chk("abort_sclk", 32'(o_sclk), 32'd0);
        chk("abort_tx_ready", 32'(o_ready), 32'd1);
        chk("abort_rx_data", 32'(o_rxd), 32'd0);
        chk("abort_busy", 32'(o_busy), 32'd0);
        any_v = 1'b0;
        ss_drop = 1'b0;
        for (int i = 0; i < 40; i++) begin
          @(negedge clk);
          if (o_rxv !== 1'b0) any_v = 1'b1;
          if (o_ss !== 1'b1) ss_drop = 1'b1;
        end
        chk("abort_no_rx_valid", 32'(any_v), 32'd0);
        chk("abort_stays_idle", 32'(ss_drop), 32'd0);
        return;
      end
    end
    chk("sclk_rises", 32'(nrise), 32'(W));
    chk("mosi_order", 32'(mosi_seq & mask), 32'(tx));
    if (!hold) tx_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; tx_valid = 1'b0; tx_data = '0; miso_drv = 1'b0;
    loop_mode = 1'b1; sel = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ss", 32'(ss8), 32'd1);
    chk("rst_sclk", 32'(sclk8), 32'd0);
    chk("rst_mosi", 32'(mosi8), 32'd0);
    chk("rst_tx_ready_low", 32'(ready8), 32'd0);
    chk("rst_rx_valid", 32'(rxv8), 32'd0);
    chk("rst_rx_data", 32'(rxd8), 32'd0);
    chk("rst_busy", 32'(busy8), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_tx_ready", 32'(ready8), 32'd1);
    chk("post_rst_ready4", 32'(ready4), 32'd1);

    run_frame(0, 8'hA5, 1, 8'h00, 0, 8'h00, 0);
    run_frame(0, 8'h00, 0, 8'hFF, 0, 8'h00, 0);
    run_frame(0, 8'h3C, 1, 8'h00, 1, 8'hC3, 0);
    run_frame(0, 8'hC3, 1, 8'h00, 0, 8'h00, 0);
    repeat (6) run_frame(0, 8'($urandom), 1'($urandom), 8'($urandom), 0, 8'h00, 0);
    // Bit 3 rises at edge 14, so cycle 15 is inside its HIGH phase.
    run_frame(0, 8'h5A, 1, 8'h00, 0, 8'h00, 15);

    run_frame(1, 8'h09, 1, 8'h00, 0, 8'h00, 0);
    repeat (5) run_frame(1, 8'($urandom), 1'($urandom), 8'($urandom), 0, 8'h00, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
